rs485_modbus_slave: RTL and testbench

- Parametrised Modbus-RTU slave engine for the RS485 screen link. It sits between the byte-level UART and the system status and parameter registers.
- It collects request frames by inter-byte gap timing and checks CRC16. It serves function 0x03 (read holding registers) from a flattened read bank of NUM_REGS words, and function 0x06 (write single register) into NUM_WREGS write slots.
- It returns replies byte-by-byte over a valid/done handshake and generates Modbus exception replies.
- It generalises the fixed-map screen analysis to a configurable slave address, register count, gap time and maximum read length.

---
 rtl/rs485_modbus_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_rs485_modbus_slave.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs485_modbus_slave.sv
// Modbus-RTU slave engine: gap-delimited frame capture, CRC16 check, 0x03/0x06 service
// and exception replies, streamed to the UART one byte per tx_valid/tx_done handshake.
module rs485_modbus_slave #(
    parameter logic [7:0]  SLAVE_ADDR = 8'h01,
    parameter int unsigned NUM_REGS   = 64,
    parameter int unsigned NUM_WREGS  = 16,
    parameter int unsigned MAX_READ   = 16,
    parameter int unsigned GAP_CYCLES = 30400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_done,
    input  logic [NUM_REGS*16-1:0] rd_regs,
    output logic [7:0]             wr_index,
    output logic [15:0]            wr_data,
    output logic                   wr_strobe,
    output logic                   busy,
    output logic [15:0]            crc_err_cnt
);
    localparam int unsigned   GW      = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {IDLE, RECV, CHECK, EXEC, SEND, WAIT_DONE} state_t;
    typedef enum logic [1:0] {RSP_READ, RSP_WRITE, RSP_EXC} rsp_t;

    state_t        state_q, state_d;
    rsp_t          rsp_q, rsp_d;
    logic [7:0]    rxb_q [8];
    logic [7:0]    rxb_d [8];
    logic [3:0]    len_q, len_d;
    logic          ovl_q, ovl_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    exc_q, exc_d;
    logic [9:0]    idx_q, idx_d, tlen_q, tlen_d;
    logic [15:0]   crc_q, crc_d;
    logic [7:0]    samp_q, samp_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    wr_index_q, wr_index_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic          busy_q, busy_d;
    logic [15:0]   crc_err_q, crc_err_d;

    logic [15:0] reg_addr, reg_val, rx_crc, rd_sel, bank_word;
    logic [16:0] rd_end;
    logic [9:0]  k;
    logic        rd_ok, wr_ok;
    logic [7:0]  tx_b;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign reg_addr = {rxb_q[2], rxb_q[3]};
    assign reg_val  = {rxb_q[4], rxb_q[5]};
    assign rd_end   = {1'b0, reg_addr} + {1'b0, reg_val};
    assign rd_ok    = (reg_val != 16'd0) && (32'(reg_val) <= MAX_READ) && (32'(rd_end) <= NUM_REGS);
    assign wr_ok    = 32'(reg_addr) < NUM_WREGS;
    // Reply bytes 3.. are register data; k/2 is the register offset, k[0] selects lo byte
    assign k        = idx_q - 10'd3;
    assign rd_sel   = reg_addr + {7'b0, k[9:1]};

    always_comb begin
        rx_crc = 16'hFFFF;
        for (int unsigned i = 0; i < 6; i++)
            rx_crc = crc_step(rx_crc, rxb_q[i]);
    end

    always_comb begin
        bank_word = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            if (rd_sel == 16'(r))
                bank_word = rd_regs[16*r +: 16];
    end

    always_comb begin
        state_d     = state_q;
        rsp_d       = rsp_q;
        rxb_d       = rxb_q;
        len_d       = len_q;
        ovl_d       = ovl_q;
        gap_d       = gap_q;
        exc_d       = exc_q;
        idx_d       = idx_q;
        tlen_d      = tlen_q;
        crc_d       = crc_q;
        samp_d      = samp_q;
        tx_byte_d   = tx_byte_q;
        tx_valid_d  = 1'b0;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
        wr_strobe_d = 1'b0;
        crc_err_d   = crc_err_q;
        tx_b        = '0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    rxb_d[0] = rx_byte;
                    len_d    = 4'd1;
                    ovl_d    = 1'b0;
                    gap_d    = '0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    gap_d = '0;
                    if (len_q < 4'd8) begin
                        rxb_d[len_q[2:0]] = rx_byte;
                        len_d             = len_q + 4'd1;
                    end else begin
                        ovl_d = 1'b1;
                    end
                end else if (gap_q == GAP_END) begin
                    state_d = CHECK;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (len_q == 4'd8 && !ovl_q && (rxb_q[0] == SLAVE_ADDR || rxb_q[0] == 8'h00)) begin
                    if (rx_crc == {rxb_q[7], rxb_q[6]})
                        state_d = EXEC;
                    else if (crc_err_q != 16'hFFFF)
                        crc_err_d = crc_err_q + 16'd1;
                end
            end
            EXEC: begin
                rsp_d  = RSP_EXC;
                exc_d  = 8'h01;
                tlen_d = 10'd5;
                if (rxb_q[1] == 8'h03) begin
                    exc_d = 8'h02;
                    if (rd_ok) begin
                        rsp_d  = RSP_READ;
                        tlen_d = 10'd5 + {reg_val[8:0], 1'b0};
                    end
                end else if (rxb_q[1] == 8'h06) begin
                    exc_d = 8'h02;
                    if (wr_ok) begin
                        rsp_d       = RSP_WRITE;
                        tlen_d      = 10'd8;
                        wr_index_d  = reg_addr[7:0];
                        wr_data_d   = reg_val;
                        wr_strobe_d = 1'b1;
                    end
                end
                idx_d   = '0;
                crc_d   = 16'hFFFF;
                state_d = (rxb_q[0] == 8'h00) ? IDLE : SEND;
            end
            SEND: begin
                // The last two bytes of every reply are the running CRC; a write echo
                // reproduces the received CRC because it covers the same six bytes.
                if (idx_q >= tlen_q - 10'd2) begin
                    tx_b = (idx_q == tlen_q - 10'd2) ? crc_q[7:0] : crc_q[15:8];
                end else begin
                    case (rsp_q)
                        RSP_WRITE: tx_b = rxb_q[idx_q[2:0]];
                        RSP_READ: begin
                            if (idx_q == 10'd0)      tx_b = rxb_q[0];
                            else if (idx_q == 10'd1) tx_b = 8'h03;
                            else if (idx_q == 10'd2) tx_b = {reg_val[6:0], 1'b0};
                            else if (!k[0]) begin
                                tx_b   = bank_word[15:8];
                                samp_d = bank_word[7:0];
                            end else begin
                                tx_b = samp_q;
                            end
                        end
                        default: begin
                            if (idx_q == 10'd0)      tx_b = rxb_q[0];
                            else if (idx_q == 10'd1) tx_b = rxb_q[1] | 8'h80;
                            else                     tx_b = exc_q;
                        end
                    endcase
                    crc_d = crc_step(crc_q, tx_b);
                end
                tx_byte_d  = tx_b;
                tx_valid_d = 1'b1;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (idx_q == tlen_q - 10'd1) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 10'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) && (state_d != RECV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_q       <= RSP_EXC;
            for (int unsigned i = 0; i < 8; i++) rxb_q[i] <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            gap_q       <= '0;
            exc_q       <= '0;
            idx_q       <= '0;
            tlen_q      <= '0;
            crc_q       <= '1;
            samp_q      <= '0;
            tx_byte_q   <= '0;
            tx_valid_q  <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            crc_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_q       <= rsp_d;
            rxb_q       <= rxb_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            gap_q       <= gap_d;
            exc_q       <= exc_d;
            idx_q       <= idx_d;
            tlen_q      <= tlen_d;
            crc_q       <= crc_d;
            samp_q      <= samp_d;
            tx_byte_q   <= tx_byte_d;
            tx_valid_q  <= tx_valid_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
            wr_strobe_q <= wr_strobe_d;
            busy_q      <= busy_d;
            crc_err_q   <= crc_err_d;
        end
    end

    assign tx_byte     = tx_byte_q;
    assign tx_valid    = tx_valid_q;
    assign wr_index    = wr_index_q;
    assign wr_data     = wr_data_q;
    assign wr_strobe   = wr_strobe_q;
    assign busy        = busy_q;
    assign crc_err_cnt = crc_err_q;
endmodule

// File: tb/tb_rs485_modbus_slave.sv
// Bench for rs485_modbus_slave: directed request frames, a frame-level reply model
// and one per-cycle monitor comparing tx bytes and write strobes against it.
module tb_rs485_modbus_slave;
    localparam int unsigned NR  = 8;
    localparam int unsigned NW  = 4;
    localparam int unsigned MR  = 4;
    localparam int unsigned GAP = 20;
    localparam logic [7:0]  SA  = 8'h01;

    typedef logic [7:0] byte_t;
    typedef byte_t bq_t[$];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_done;
    logic [NR*16-1:0] rd_regs;
    logic [7:0]       wr_index;
    logic [15:0]      wr_data;
    logic             wr_strobe;
    logic             busy;
    logic [15:0]      crc_err_cnt;

    rs485_modbus_slave #(
        .SLAVE_ADDR(SA), .NUM_REGS(NR), .NUM_WREGS(NW), .MAX_READ(MR), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_done(tx_done), .rd_regs(rd_regs),
        .wr_index(wr_index), .wr_data(wr_data), .wr_strobe(wr_strobe), .busy(busy),
        .crc_err_cnt(crc_err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    byte_t       exp_q[$];
    logic [23:0] exp_wr[$];
    logic [15:0] exp_crc_err = 16'd0;
    int unsigned tx_seen = 0;
    int unsigned rst_epoch = 0;
    bit          pending = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] crc16(input bq_t d);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[i]) begin
            c = c ^ {8'h00, d[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bq_t with_crc(input bq_t d);
        bq_t r;
        logic [15:0] c;
        r = d;
        c = crc16(d);
        r.push_back(c[7:0]);
        r.push_back(c[15:8]);
        return r;
    endfunction

    // Frame-level model: decides from the whole received frame what must come back.
    task automatic model_frame(input bq_t f);
        bq_t h, r;
        int unsigned a, n;
        logic [15:0] v;
        bit echo;
        echo = 1'b0;
        if (f.size() != 8) return;
        if (f[0] != SA && f[0] != 8'h00) return;
        for (int i = 0; i < 6; i++) h.push_back(f[i]);
        if (crc16(h) != {f[7], f[6]}) begin
            if (exp_crc_err != 16'hFFFF) exp_crc_err = exp_crc_err + 16'd1;
            return;
        end
        a = 32'({f[2], f[3]});
        n = 32'({f[4], f[5]});
        if (f[1] == 8'h03 && n >= 1 && n <= MR && a + n <= NR) begin
            r.push_back(f[0]); r.push_back(8'h03); r.push_back(byte_t'(2 * n));
            for (int unsigned j = a; j < a + n; j++) begin
                v = rd_regs[16*j +: 16];
                r.push_back(v[15:8]); r.push_back(v[7:0]);
            end
        end else if (f[1] == 8'h06 && a < NW) begin
            exp_wr.push_back({f[3], f[4], f[5]});
            r = f;
            echo = 1'b1;
        end else begin
            r.push_back(f[0]); r.push_back(f[1] | 8'h80);
            r.push_back((f[1] == 8'h03 || f[1] == 8'h06) ? 8'h02 : 8'h01);
        end
        if (f[0] == 8'h00) return;
        if (!echo) r = with_crc(r);
        foreach (r[i]) exp_q.push_back(r[i]);
    endtask

    task automatic send_bytes(input bq_t f);
        foreach (f[i]) begin
            @(negedge clk);
            rx_byte  = f[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic settle();
        int unsigned cnt;
        cnt = 0;
        repeat (GAP + 8) @(negedge clk);
        while ((busy || exp_q.size() != 0) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 2000) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: busy=%0d pending_bytes=%0d, required idle", busy, exp_q.size());
        end
        check("reply_drained", exp_q.size(), 0);
        check("writes_drained", exp_wr.size(), 0);
        check("crc_err_cnt", crc_err_cnt, exp_crc_err);
        check("busy_idle", busy, 0);
    endtask

    task automatic run_frame(input bq_t f);
        model_frame(f);
        send_bytes(f);
        settle();
    endtask

    task automatic run_req(input logic [47:0] v);
        bq_t q;
        for (int i = 5; i >= 0; i--) q.push_back(v[8*i +: 8]);
        run_frame(with_crc(q));
    endtask

    // UART stand-in: completes each byte a few cycles after the request
    always begin : uart_tx
        byte_t hold;
        int unsigned ep;
        @(negedge clk);
        if (tx_valid && !rst) begin
            hold = tx_byte;
            ep   = rst_epoch;
            repeat (3) @(negedge clk);
            if (ep == rst_epoch) check("tx_byte_stable", tx_byte, hold);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (tx_done) pending = 1'b0;
            if (tx_valid) begin
                check("tx_one_per_done", pending, 0);
                check("tx_busy", busy, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %02h, required no byte", tx_byte);
                end else begin
                    check("tx_byte", tx_byte, exp_q.pop_front());
                end
                pending = 1'b1;
                tx_seen++;
            end
            if (wr_strobe) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got %02h/%04h, required no write", wr_index, wr_data);
                end else begin
                    check("wr_event", {wr_index, wr_data}, exp_wr.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f, g;
        int unsigned base, at_rst, cnt;
        rx_byte  = '0;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        for (int k = 0; k < NR; k++)
            rd_regs[16*k +: 16] = (k == 0) ? 16'h1234 : {8'hA0 + 8'(k), 8'h50 + 8'(k)};

        repeat (3) @(negedge clk);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_wr_index", wr_index, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_crc_err", crc_err_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        check("pin_crc_read_req", crc16(f), 16'h0A84);
        f = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        check("pin_crc_write_req", crc16(f), 16'h0B98);

        f = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        run_frame(f);
        check("write_index", wr_index, 8'h01);
        check("write_data", wr_data, 16'h0003);

        f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        model_frame(f);
        check("pin_read_len", exp_q.size(), 7);
        check("pin_read_hdr", {exp_q[0], exp_q[1], exp_q[2]}, 24'h010302);
        check("pin_read_data", {exp_q[3], exp_q[4]}, 16'h1234);
        send_bytes(f);
        settle();

        f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
        run_frame(f);
        check("bad_crc_count", crc_err_cnt, 16'd1);

        run_req(48'h01_03_0000_0005);
        run_req(48'h01_03_0007_0002);
        run_req(48'h01_03_0006_0002);
        run_req(48'h01_03_0004_0004);
        run_req(48'h01_03_0000_0000);

        g = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01};
        f = with_crc(g);
        model_frame(f);
        check("pin_exc_func", {exp_q[0], exp_q[1], exp_q[2]}, 24'h019001);
        send_bytes(f);
        settle();

        run_req(48'h01_06_0004_1111);
        run_req(48'h01_06_0003_BEEF);
        run_req(48'h05_03_0000_0001);

        g = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        f = with_crc(g);
        f.push_back(8'h00);
        run_frame(f);

        g = '{8'h01, 8'h03, 8'h00, 8'h00};
        model_frame(g);
        send_bytes(g);
        repeat (GAP + 10) @(negedge clk);
        g = '{8'h00, 8'h01, 8'h84, 8'h0A};
        model_frame(g);
        send_bytes(g);
        settle();

        run_req(48'h00_06_0002_ABCD);
        check("bcast_index", wr_index, 8'h02);
        check("bcast_data", wr_data, 16'hABCD);
        run_req(48'h00_03_0000_0001);

        g = '{8'h01, 8'h03, 8'h00, 8'h04, 8'h00, 8'h04};
        f = with_crc(g);
        model_frame(f);
        base = tx_seen;
        send_bytes(f);
        cnt = 0;
        while (tx_seen < base + 3 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (tx_seen < base + 3) begin
            checks++;
            errors++;
            $display("FAIL reset_wait: got %0d reply bytes, required 3", tx_seen - base);
        end
        rst = 1'b1;
        rst_epoch++;
        exp_q.delete();
        exp_wr.delete();
        exp_crc_err = 16'd0;
        repeat (2) @(negedge clk);
        check("mid_rst_tx_byte", tx_byte, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_wr_index", wr_index, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_crc_err", crc_err_cnt, 0);
        at_rst = tx_seen;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("no_tx_after_reset", tx_seen, at_rst);

        f = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        run_frame(f);
        check("post_rst_wr_index", wr_index, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
